gbt_rx_link_supervisor: RTL and testbench
=========================================

Name: gbt_rx_link_supervisor

Overview:
- Sits directly downstream of gbt_xu5 in the 40 MHz frame clock domain and consumes the received GBT frame stream.
- Qualifies frames with a lock state machine and forwards only frames received while the link is up.
- Keeps saturating error, frame and relock statistics for the MCOI status registers.
- Drives the link_up flag that gates motor command decoding.

Parameters:
- LOCK_FRAMES, 64, consecutive good frames needed to declare the link up (range 1..255)
- UNLOCK_ERRORS, 4, consecutive bad frames that drop the link (range 1..15)
- FRAME_W, 84, received GBT frame width in bits

Ports:
- ClkRs_ix  input  ckrs_t  clock/reset bundle; .clk is the 40 MHz frame clock; .reset is asynchronous, active-high
- sfp_los_i  input  1  SFP loss of signal, already synchronised
- rx_ready_i  input  1  GBT RX ready from gbt_xu5
- rx_valid_i  input  1  frame strobe, one cycle per received frame
- rx_header_ok_i  input  1  header/flag valid for the current frame
- rx_frame_ib  input  FRAME_W  received frame payload
- clear_stats_i  input  1  single-cycle clear of all counters
- link_up_o  output  1  link qualified
- state_o  output  2  current supervisor state
- frame_valid_o  output  1  forwarded frame strobe
- frame_ob  output  FRAME_W  forwarded frame
- err_cnt_ob  output  16  bad-frame counter, saturating
- frame_cnt_ob  output  32  forwarded-frame counter, wrapping
- relock_cnt_ob  output  8  LOCKED->DEGRADED transitions, saturating

Behaviour:
- Reset values: every output 0; state_o = DOWN (2'd0).
- A frame is good when rx_valid_i & rx_header_ok_i are both 1. It is bad when rx_valid_i=1 and rx_header_ok_i=0. Cycles with rx_valid_i=0 are ignored.
- Any state goes to DOWN in the next cycle when sfp_los_i=1 or rx_ready_i=0. This override beats every other transition. The run counters clear.
- DOWN (0): go to ACQUIRE when sfp_los_i=0 and rx_ready_i=1.
- ACQUIRE (1):
  - Each good frame increments the good-run counter; a bad frame clears it.
  - When the counter reaches LOCK_FRAMES, go to LOCKED. The LOCK_FRAMES-th good frame itself is not forwarded.
- LOCKED (2):
  - A good frame is forwarded with a 1-cycle registered latency: frame_ob and frame_valid_o appear the cycle after rx_valid_i.
  - A bad frame is not forwarded, increments err_cnt_ob, and moves to DEGRADED with the bad-run counter set to 1.
- DEGRADED (3):
  - A good frame is forwarded, clears the bad-run counter and returns to LOCKED.
  - A bad frame increments err_cnt_ob and the bad-run counter. When the bad-run counter reaches UNLOCK_ERRORS, go to ACQUIRE and increment relock_cnt_ob.
- link_up_o = 1 in LOCKED and DEGRADED. It is registered and consistent with state_o.
- frame_ob holds its last value when frame_valid_o=0.
- err_cnt_ob saturates at 16'hFFFF; relock_cnt_ob saturates at 8'hFF; frame_cnt_ob wraps modulo 2^32.
- err_cnt_ob also counts bad frames in ACQUIRE.
- clear_stats_i coinciding with an increment: the clear wins, and the counter reads 0 next cycle.
- Asynchronous reset mid-frame: outputs clear immediately. An in-flight forwarded frame is discarded.

Optional Feature:
- Macro: GBT_RX_PATTERN_CHECK_EN.
- Compiled in, LOCKED/DEGRADED checks on every forwarded frame:
  - motor_data_b64[63:32] == motor_data_b64[31:0].
  - The low word equals the previous forwarded low word +1, wrapping.
  - The first frame after entering LOCKED only seeds the reference.
  - Violations increment an extra output pattern_err_cnt_ob (16 bits, saturating, cleared by clear_stats_i). They do not affect the state machine.
- Without the macro: the port is absent and no checker logic is synthesised.

Decomposition:
- Package MCPkg gets:
  - the enum for the four states, encoded to match state_o;
  - the LOCK_FRAMES and UNLOCK_ERRORS default constants;
  - the motor_data_b64 field offset within the frame.
- Natural sub-module: gbt_rx_sat_counter, a parameterised-width saturating/wrapping counter with clear priority. It is used for all statistics counters.

Test Plan:
- Reset, then sfp_los_i=1 for 1 µs -> state_o=0, link_up_o=0, no frame_valid_o.
- Release LOS, rx_ready_i=1, 64 good frames -> state_o reaches 2 one cycle after the 64th frame; the 65th frame is forwarded one cycle later; frame_cnt_ob=1.
- In LOCKED, 3 bad frames then 1 good -> state 3 then 2, err_cnt_ob=3, relock_cnt_ob=0. Then 4 bad frames -> state 1, relock_cnt_ob=1, link_up_o=0.
- In LOCKED, drop rx_ready_i for one cycle -> state_o=0 next cycle; reacquisition needs 64 fresh good frames.
- clear_stats_i asserted together with a bad frame at err_cnt_ob=16'hFFFF -> err_cnt_ob=0 next cycle. Separately, err_cnt_ob stays at 16'hFFFF after an extra bad frame.
- With GBT_RX_PATTERN_CHECK_EN, feed an incrementing {n,n} pattern with one skipped value -> pattern_err_cnt_ob=1, state stays 2.

Source files
------------

// File: rtl/gbt_rx_link_supervisor_pkg.sv
// Shared types and constants for the GBT RX link supervisor.
// The GBT_RX_PATTERN_CHECK_EN build option is handled in the top file.
package MCPkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  // The encoding is visible on state_o, so it must not change.
  typedef enum logic [1:0] {
    ST_DOWN     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_DEGRADED = 2'd3
  } sup_state_e;

  localparam int LOCK_FRAMES_DEF   = 64;
  localparam int UNLOCK_ERRORS_DEF = 4;

  // Position and width of motor_data_b64 inside the received frame
  localparam int MOTOR_DATA_OFS = 0;
  localparam int MOTOR_DATA_W   = 64;

endpackage

// File: rtl/gbt_rx_link_supervisor_sat_counter.sv
// Statistics counter: clear has priority over increment; optional saturation at all-ones.
module gbt_rx_sat_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(SATURATE && (cnt_q == '1))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_rx_link_supervisor.sv
// Link lock supervisor for the received GBT frame stream: qualifies frames, forwards them while
// the link is up and keeps link statistics. Optional motor-data pattern checker: GBT_RX_PATTERN_CHECK_EN.
module gbt_rx_link_supervisor
  import MCPkg::*;
#(
  parameter int LOCK_FRAMES   = LOCK_FRAMES_DEF,
  parameter int UNLOCK_ERRORS = UNLOCK_ERRORS_DEF,
  parameter int FRAME_W       = 84
) (
  input  ckrs_t              ClkRs_ix,
  input  logic               sfp_los_i,
  input  logic               rx_ready_i,
  input  logic               rx_valid_i,
  input  logic               rx_header_ok_i,
  input  logic [FRAME_W-1:0] rx_frame_ib,
  input  logic               clear_stats_i,
  output logic               link_up_o,
  output logic [1:0]         state_o,
  output logic               frame_valid_o,
  output logic [FRAME_W-1:0] frame_ob,
  output logic [15:0]        err_cnt_ob,
  output logic [31:0]        frame_cnt_ob,
  output logic [7:0]         relock_cnt_ob
`ifdef GBT_RX_PATTERN_CHECK_EN
  ,
  output logic [15:0]        pattern_err_cnt_ob
`endif
);

  localparam logic [7:0] LOCK_CMP   = 8'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_CMP = 4'(UNLOCK_ERRORS);

  logic clk;
  logic rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  sup_state_e         state_q, state_d;
  logic [7:0]         good_run_q, good_run_d;
  logic [3:0]         bad_run_q, bad_run_d;
  logic               link_up_q, link_up_d;
  logic               frame_valid_q, frame_valid_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               good, bad, fwd, err_inc, relock_inc;

  assign good = rx_valid_i & rx_header_ok_i;
  assign bad  = rx_valid_i & ~rx_header_ok_i;

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    fwd        = 1'b0;
    err_inc    = 1'b0;
    relock_inc = 1'b0;
    // Losing the optical signal or GBT ready overrides everything, frames included.
    if (sfp_los_i || !rx_ready_i) begin
      state_d    = ST_DOWN;
      good_run_d = '0;
      bad_run_d  = '0;
    end else begin
      case (state_q)
        ST_DOWN: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (good) begin
            if (good_run_q + 8'd1 == LOCK_CMP) begin
              state_d    = ST_LOCKED;
              good_run_d = '0;
            end else begin
              good_run_d = good_run_q + 8'd1;
            end
          end else if (bad) begin
            good_run_d = '0;
            err_inc    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            fwd = 1'b1;
          end else if (bad) begin
            err_inc = 1'b1;
            if (UNLOCK_CMP == 4'd1) begin
              state_d    = ST_ACQUIRE;
              relock_inc = 1'b1;
              bad_run_d  = '0;
            end else begin
              state_d   = ST_DEGRADED;
              bad_run_d = 4'd1;
            end
          end
        end
        default: begin
          if (good) begin
            fwd       = 1'b1;
            bad_run_d = '0;
            state_d   = ST_LOCKED;
          end else if (bad) begin
            err_inc = 1'b1;
            if (bad_run_q + 4'd1 == UNLOCK_CMP) begin
              state_d    = ST_ACQUIRE;
              relock_inc = 1'b1;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
      endcase
    end
    link_up_d     = (state_d == ST_LOCKED) || (state_d == ST_DEGRADED);
    frame_valid_d = fwd;
    frame_d       = fwd ? rx_frame_ib : frame_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_DOWN;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      link_up_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_q       <= '0;
    end else begin
      state_q       <= state_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      link_up_q     <= link_up_d;
      frame_valid_q <= frame_valid_d;
      frame_q       <= frame_d;
    end
  end

  assign link_up_o     = link_up_q;
  assign state_o       = state_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_ob      = frame_q;

  gbt_rx_sat_counter #(.W(16), .SATURATE(1'b1)) u_err_cnt (
    .clk(clk), .rst(rst), .clr_i(clear_stats_i), .inc_i(err_inc), .cnt_o(err_cnt_ob)
  );

  gbt_rx_sat_counter #(.W(32), .SATURATE(1'b0)) u_frame_cnt (
    .clk(clk), .rst(rst), .clr_i(clear_stats_i), .inc_i(fwd), .cnt_o(frame_cnt_ob)
  );

  gbt_rx_sat_counter #(.W(8), .SATURATE(1'b1)) u_relock_cnt (
    .clk(clk), .rst(rst), .clr_i(clear_stats_i), .inc_i(relock_inc), .cnt_o(relock_cnt_ob)
  );

`ifdef GBT_RX_PATTERN_CHECK_EN
  logic [MOTOR_DATA_W-1:0] motor_data_b64;
  logic                    pat_seeded_q, pat_seeded_d;
  logic [31:0]             pat_prev_q, pat_prev_d;
  logic                    pat_err;

  assign motor_data_b64 = rx_frame_ib[MOTOR_DATA_OFS +: MOTOR_DATA_W];

  // The reference is dropped whenever the link is not up, so the first frame after locking only seeds it.
  always_comb begin
    pat_seeded_d = pat_seeded_q;
    pat_prev_d   = pat_prev_q;
    pat_err      = 1'b0;
    if ((state_q != ST_LOCKED) && (state_q != ST_DEGRADED)) begin
      pat_seeded_d = 1'b0;
    end else if (fwd) begin
      pat_seeded_d = 1'b1;
      pat_prev_d   = motor_data_b64[31:0];
      if (pat_seeded_q && ((motor_data_b64[63:32] != motor_data_b64[31:0]) ||
                           (motor_data_b64[31:0] != pat_prev_q + 32'd1))) begin
        pat_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_seeded_q <= 1'b0;
      pat_prev_q   <= '0;
    end else begin
      pat_seeded_q <= pat_seeded_d;
      pat_prev_q   <= pat_prev_d;
    end
  end

  gbt_rx_sat_counter #(.W(16), .SATURATE(1'b1)) u_pattern_err_cnt (
    .clk(clk), .rst(rst), .clr_i(clear_stats_i), .inc_i(pat_err), .cnt_o(pattern_err_cnt_ob)
  );
`endif

endmodule

// File: tb/tb_gbt_rx_link_supervisor.sv
// Self-checking bench for gbt_rx_link_supervisor; forwarded frames are checked against an expected queue.
module tb_gbt_rx_link_supervisor;
  import MCPkg::*;

  localparam int FW = 84;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  ckrs_t         clk_rs;
  logic          sfp_los, rx_ready, rx_valid, rx_hok, clear_stats;
  logic [FW-1:0] rx_frame;
  logic          link_up_o, frame_valid_o;
  logic [1:0]    state_o;
  logic [FW-1:0] frame_ob;
  logic [15:0]   err_cnt_ob;
  logic [31:0]   frame_cnt_ob;
  logic [7:0]    relock_cnt_ob;
`ifdef GBT_RX_PATTERN_CHECK_EN
  logic [15:0]   pattern_err_cnt_ob;
`endif

  int            pass_cnt = 0;
  int            check_cnt = 0;
  logic [FW-1:0] exp_q[$];
  int            exp_err = 0;
  int            exp_frames = 0;
  int            exp_relock = 0;
  logic [FW-1:0] last_fwd = '0;

  assign clk_rs.clk   = clk;
  assign clk_rs.reset = rst;

  always #5 clk = ~clk;

  gbt_rx_link_supervisor dut (
    .ClkRs_ix(clk_rs),
    .sfp_los_i(sfp_los),
    .rx_ready_i(rx_ready),
    .rx_valid_i(rx_valid),
    .rx_header_ok_i(rx_hok),
    .rx_frame_ib(rx_frame),
    .clear_stats_i(clear_stats),
    .link_up_o(link_up_o),
    .state_o(state_o),
    .frame_valid_o(frame_valid_o),
    .frame_ob(frame_ob),
    .err_cnt_ob(err_cnt_ob),
    .frame_cnt_ob(frame_cnt_ob),
    .relock_cnt_ob(relock_cnt_ob)
`ifdef GBT_RX_PATTERN_CHECK_EN
    ,
    .pattern_err_cnt_ob(pattern_err_cnt_ob)
`endif
  );

  // Scoreboard: every forwarded frame must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && frame_valid_o) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL fwd_unexpected got frame %h, required no frame_valid_o", frame_ob);
      end else begin
        logic [FW-1:0] exp;
        exp = exp_q.pop_front();
        if (frame_ob !== exp) $display("FAIL fwd_data got %h required %h", frame_ob, exp);
        else pass_cnt++;
      end
    end
  end

  function automatic logic [FW-1:0] rand_frame();
    return FW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic hok, input logic [FW-1:0] d, input bit expect_fwd);
    rx_valid = 1'b1;
    rx_hok   = hok;
    rx_frame = d;
    if (expect_fwd) begin
      exp_q.push_back(d);
      exp_frames++;
      last_fwd = d;
    end
    if (!hok) exp_err++;
    step();
    rx_valid = 1'b0;
    rx_hok   = 1'b0;
  endtask

  task automatic send_good_n(input int n);
    for (int i = 0; i < n; i++) send(1'b1, rand_frame(), 1'b0);
  endtask

  task automatic test_reset();
    bit bad_seen;
    sfp_los = 1'b1; rx_ready = 1'b0; rx_valid = 1'b0; rx_hok = 1'b0;
    rx_frame = '0; clear_stats = 1'b0; rst = 1'b1;
    repeat (3) step();
    check_cnt++;
    if ({link_up_o, state_o, frame_valid_o, frame_ob, err_cnt_ob, frame_cnt_ob, relock_cnt_ob} !== '0)
      $display("FAIL reset_outputs got state=%0d link=%b valid=%b err=%0d frames=%0d relock=%0d required all 0",
               state_o, link_up_o, frame_valid_o, err_cnt_ob, frame_cnt_ob, relock_cnt_ob);
    else pass_cnt++;
    rst = 1'b0;
    rx_ready = 1'b1;
    bad_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rx_valid = 1'b1; rx_hok = 1'b1; rx_frame = rand_frame();
      step();
      if (state_o !== 2'd0 || link_up_o !== 1'b0 || frame_valid_o !== 1'b0) bad_seen = 1'b1;
    end
    rx_valid = 1'b0; rx_hok = 1'b0;
    check_cnt++;
    if (bad_seen) $display("FAIL los_hold got state=%0d link=%b, required state 0 link 0 during LOS", state_o, link_up_o);
    else pass_cnt++;
  endtask

  task automatic test_acquire();
    sfp_los = 1'b0;
    step();
    check_cnt++;
    if (state_o !== 2'd1) $display("FAIL acq_enter got state %0d required 1", state_o);
    else pass_cnt++;
    send_good_n(10);
    send(1'b0, rand_frame(), 1'b0);
    send_good_n(63);
    check_cnt++;
    if (state_o !== 2'd1 || link_up_o !== 1'b0) $display("FAIL acq_63 got state %0d link %b required 1/0", state_o, link_up_o);
    else pass_cnt++;
    send_good_n(1);
    check_cnt++;
    if (state_o !== 2'd2 || link_up_o !== 1'b1) $display("FAIL acq_lock got state %0d link %b required 2/1", state_o, link_up_o);
    else pass_cnt++;
    send(1'b1, rand_frame(), 1'b1);
    check_cnt++;
    if (frame_cnt_ob !== 32'(exp_frames) || err_cnt_ob !== 16'(exp_err))
      $display("FAIL acq_counts got frames %0d err %0d required %0d/%0d", frame_cnt_ob, err_cnt_ob, exp_frames, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_degrade();
    send(1'b0, rand_frame(), 1'b0);
    check_cnt++;
    if (state_o !== 2'd3 || link_up_o !== 1'b1) $display("FAIL deg_enter got state %0d link %b required 3/1", state_o, link_up_o);
    else pass_cnt++;
    send(1'b0, rand_frame(), 1'b0);
    send(1'b0, rand_frame(), 1'b0);
    send(1'b1, rand_frame(), 1'b1);
    check_cnt++;
    if (state_o !== 2'd2 || err_cnt_ob !== 16'(exp_err) || relock_cnt_ob !== 8'd0)
      $display("FAIL deg_recover got state %0d err %0d relock %0d required 2/%0d/0", state_o, err_cnt_ob, relock_cnt_ob, exp_err);
    else pass_cnt++;
    step();
    check_cnt++;
    if (frame_ob !== last_fwd) $display("FAIL frame_hold got %h required %h", frame_ob, last_fwd);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) send(1'b0, rand_frame(), 1'b0);
    check_cnt++;
    if (state_o !== 2'd3) $display("FAIL deg_3bad got state %0d required 3", state_o);
    else pass_cnt++;
    send(1'b0, rand_frame(), 1'b0);
    exp_relock++;
    check_cnt++;
    if (state_o !== 2'd1 || link_up_o !== 1'b0 || relock_cnt_ob !== 8'(exp_relock) || err_cnt_ob !== 16'(exp_err))
      $display("FAIL deg_unlock got state %0d link %b relock %0d err %0d required 1/0/%0d/%0d",
               state_o, link_up_o, relock_cnt_ob, err_cnt_ob, exp_relock, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_ready_drop();
    send_good_n(30);
    rx_ready = 1'b0;
    step();
    check_cnt++;
    if (state_o !== 2'd0) $display("FAIL drop_acq got state %0d required 0", state_o);
    else pass_cnt++;
    rx_ready = 1'b1;
    step();
    send_good_n(63);
    check_cnt++;
    if (state_o !== 2'd1) $display("FAIL drop_run_clear got state %0d required 1", state_o);
    else pass_cnt++;
    send_good_n(1);
    rx_ready = 1'b0;
    step();
    check_cnt++;
    if (state_o !== 2'd0 || link_up_o !== 1'b0) $display("FAIL drop_locked got state %0d link %b required 0/0", state_o, link_up_o);
    else pass_cnt++;
    rx_ready = 1'b1;
    step();
    send_good_n(63);
    check_cnt++;
    if (state_o !== 2'd1) $display("FAIL relock_63 got state %0d required 1", state_o);
    else pass_cnt++;
    send_good_n(1);
    check_cnt++;
    if (state_o !== 2'd2 || link_up_o !== 1'b1) $display("FAIL relock_64 got state %0d link %b required 2/1", state_o, link_up_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    rx_valid = 1'b1; rx_hok = 1'b1; rx_frame = rand_frame();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if ({link_up_o, state_o, frame_valid_o, frame_ob, err_cnt_ob, frame_cnt_ob, relock_cnt_ob} !== '0)
      $display("FAIL async_reset got state=%0d link=%b valid=%b err=%0d frames=%0d required all 0",
               state_o, link_up_o, frame_valid_o, err_cnt_ob, frame_cnt_ob);
    else pass_cnt++;
    rx_valid = 1'b0; rx_hok = 1'b0;
    step();
    rst = 1'b0;
    exp_err = 0; exp_frames = 0; exp_relock = 0;
    step();
  endtask

  task automatic test_err_saturation();
    rx_valid = 1'b1; rx_hok = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check_cnt++;
    if (err_cnt_ob !== 16'hFFFF || state_o !== 2'd1) $display("FAIL err_reach_max got %h state %0d required FFFF/1", err_cnt_ob, state_o);
    else pass_cnt++;
    step();
    check_cnt++;
    if (err_cnt_ob !== 16'hFFFF) $display("FAIL err_saturate got %h required FFFF", err_cnt_ob);
    else pass_cnt++;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check_cnt++;
    if (err_cnt_ob !== 16'h0000) $display("FAIL err_clear_wins got %h required 0000", err_cnt_ob);
    else pass_cnt++;
    step();
    rx_valid = 1'b0;
    check_cnt++;
    if (err_cnt_ob !== 16'h0001) $display("FAIL err_after_clear got %h required 0001", err_cnt_ob);
    else pass_cnt++;
    exp_err = 1;
  endtask

  task automatic test_back_to_back();
    send_good_n(64);
    for (int i = 0; i < 8; i++) send(1'b1, rand_frame(), 1'b1);
    check_cnt++;
    if (frame_cnt_ob !== 32'(exp_frames) || state_o !== 2'd2)
      $display("FAIL b2b_count got frames %0d state %0d required %0d/2", frame_cnt_ob, state_o, exp_frames);
    else pass_cnt++;
  endtask

`ifdef GBT_RX_PATTERN_CHECK_EN
  task automatic test_pattern();
    int vals[5] = '{100, 101, 102, 104, 105};
    logic [31:0] n;
    rx_ready = 1'b0;
    step();
    rx_ready = 1'b1;
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    exp_frames = 0;
    send_good_n(64);
    for (int i = 0; i < 5; i++) begin
      n = 32'(vals[i]);
      send(1'b1, FW'({n, n}), 1'b1);
    end
    check_cnt++;
    if (pattern_err_cnt_ob !== 16'd1 || state_o !== 2'd2)
      $display("FAIL pattern_skip got cnt %0d state %0d required 1/2", pattern_err_cnt_ob, state_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_acquire();
    test_degrade();
    test_ready_drop();
    test_async_reset();
    test_err_saturation();
    test_back_to_back();
`ifdef GBT_RX_PATTERN_CHECK_EN
    test_pattern();
`endif
    repeat (3) step();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL fwd_missing got %0d frames outstanding required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
